// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_arith_pkg;

    // FSM encoding shared by the serial arithmetic controllers
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand / result width
    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand and result handshake bundle for the serial subtractor.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and the result channel.
interface serial_subtractor_if #(
    parameter int WIDTH = serial_arith_pkg::DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    // Operand source / result consumer side
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow
    );

    // Subtractor side
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
// Latency: combinational.
// Backpressure: none.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a, or when they match and a borrow is pending
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH plus borrow, LSB first.
// Latency: out_valid rises WIDTH edges after the operand accept edge.
// Backpressure: result held in DONE until out_ready; no operand accepted until then.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  sub_if
);
    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic              br_q, br_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              borrow_q, borrow_d;
    logic              in_ready_q;
    logic              out_valid_q;

    logic              cell_d;
    logic              cell_bout;
    logic [WIDTH-1:0]  res_shift;

    full_subtractor u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // New difference bit enters at the MSB so the LSB-first stream lands in place
    if (WIDTH == 1) begin : g_res_w1
        assign res_shift = cell_d;
    end else begin : g_res_wn
        assign res_shift = {cell_d, res_q[WIDTH-1:1]};
    end

    // Next-state and datapath update for the IDLE/RUN/DONE controller
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (sub_if.in_valid && in_ready_q) begin
                    a_sh_d  = sub_if.a;
                    b_sh_d  = sub_if.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = cell_bout;
                res_d  = res_shift;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    diff_d   = res_shift;
                    borrow_d = cell_bout;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_valid_q && sub_if.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered handshake flags; reset clears everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            br_q        <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            br_q        <= br_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign sub_if.in_ready  = in_ready_q;
    assign sub_if.out_valid = out_valid_q;
    assign sub_if.diff      = diff_q;
    assign sub_if.borrow    = borrow_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Bit-serial unsigned subtractor: computes `diff = (a - b) mod 2^WIDTH` and a `borrow` flag, one bit per clock, LSB first.
- Operands are accepted and the result is returned over valid/ready handshakes.
- It is the inverse-direction companion to the half-adder arithmetic cells: it undoes an addition and reports underflow.
- It sits between an operand source and a result consumer, trading latency for a single 1-bit cell.

## Interface

Parameters:
- `WIDTH`, default 8. Operand and result width; legal for `WIDTH >= 1`.

Ports:
- `clk`  input  1  Single clock; all state changes on the rising edge.
- `rst_n`  input  1  Asynchronous, active-low reset.
- `in_valid`  input  1  Operand pair offered.
- `in_ready`  output  1  Block can accept operands (registered).
- `a`  input  WIDTH  Minuend; sampled only on input handshake.
- `b`  input  WIDTH  Subtrahend; sampled only on input handshake.
- `out_valid`  output  1  Result available (registered).
- `out_ready`  input  1  Consumer takes the result.
- `diff`  output  WIDTH  `a - b` modulo `2^WIDTH`.
- `borrow`  output  1  1 iff `a < b` (unsigned).

## Operation

States: IDLE, RUN, DONE.

- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`: load shift registers `a_sh <= a`, `b_sh <= b`; clear `br`, `cnt`, and the result register; go to RUN.
- **RUN**
  - Each cycle: `d = a_sh[0] ^ b_sh[0] ^ br`; `br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br)`.
  - `d` shifts into the result MSB; `a_sh` and `b_sh` shift right; `cnt` increments.
  - When `cnt == WIDTH-1`: go to DONE.
  - On that final edge, `diff` takes the full result and `borrow` takes `br_next`.
- **DONE**
  - `out_valid` = 1; `diff` and `borrow` are held stable.
  - On `out_valid && out_ready`: go to IDLE.

Other rules:
- `in_ready` is 0 in RUN and DONE. `in_valid` is ignored there, and `a`/`b` are not sampled.
- There is no same-cycle bypass: the result handshake and a new operand acceptance cannot happen on the same edge.
- `cnt` width is `$clog2(WIDTH)+1`, so `WIDTH=1` and powers of two need no special case.
- `diff` and `borrow` remain valid after the output handshake until the next result overwrites them. Consumers qualify with `out_valid` only.

## Timing

Reset (asynchronous, immediate on `rst_n` low, regardless of state, including mid-RUN):
- State = IDLE.
- `in_ready = 0`, `out_valid = 0`, `diff = 0`, `borrow = 0`; shift registers, `br` and `cnt` = 0.
- The first rising edge after `rst_n` rises sets `in_ready = 1`.

Latency and throughput:
- Input accepted at edge E0 → `out_valid` rises after edge E0+WIDTH.
- With `out_ready` held high, the output handshake occurs at E0+WIDTH+1, and `in_ready` is 1 after that edge.
- Next input accept is possible at E0+WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.

Handshakes and boundaries:
- Backpressure: `out_ready` low holds DONE indefinitely with `diff`/`borrow` stable.
- A valid/ready pair may stay asserted across multiple cycles; each transfer happens exactly once, on the edge where both are 1.
- Boundaries: `0-0` → `0`/0; `0-1` → all-ones/1; `max-max` → `0`/0; `a==b` → `0`/0.

## Structure

Shared package `serial_arith_pkg`:
- State encoding typedef with values IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Default `WIDTH` constant.

Sub-module `full_subtractor`:
- Combinational bit cell with ports `a`, `b`, `bin` → `d`, `bout`, instantiated once.
- Unit-testable on its own, alongside the half adder.

Top level holds the FSM, counter, shift registers, borrow flop and output registers.

## Test plan

All scenarios use WIDTH=8.

1. Basic subtraction: `a=0x05`, `b=0x03` → `diff=0x02`, `borrow=0`; `out_valid` rises exactly 8 edges after the accept edge.
2. Underflow: `a=0x03`, `b=0x05` → `diff=0xFE`, `borrow=1`.
3. Boundary operands, each a separate operation:
   - `0x00-0x00` → `0x00`/0.
   - `0x00-0x01` → `0xFF`/1.
   - `0xFF-0xFF` → `0x00`/0.
   - `0x80-0x01` → `0x7F`/0.
4. Backpressure: hold `out_ready=0` for 5 cycles in DONE → `diff`/`borrow` unchanged and `in_ready=0`. A concurrent `in_valid` with `a=0xAA` is not accepted, and the result is unaffected.
5. Reset mid-operation: assert `rst_n=0` three cycles into RUN → all outputs 0 immediately, without waiting for a clock edge. After release, `in_ready=1` after one edge, and a fresh `0x10-0x20` yields `0xF0`/1.
6. Back-to-back streaming: tie `out_ready=1` and `in_valid=1` across two operations (`0x09-0x04`, `0x04-0x09`) → results `0x05`/0 then `0xFB`/1, with accept edges exactly 10 cycles apart.
